// File: rtl/ahb_burst_read_handler.sv
// AHB burst read data-phase handler: tracks one outstanding address phase and
// turns each completed data phase into a register-file write strobe.
module ahb_burst_read_handler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 26,
  parameter int RF_AW  = 5,
  parameter int BEAT_W = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [5:0]        state,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] RESPONSE,
  output logic [RF_AW-1:0]  RESPONSE_ADDR,
  output logic              REG_ENABLE,
  output logic              REG_WRITE,
  output logic [BEAT_W-1:0] BEAT_CNT,
  output logic              RD_DONE,
  output logic              RD_ERR
);

  localparam logic [5:0] ST_SBURSTR = 6'b000100;
  localparam logic [5:0] ST_INCRBR  = 6'b010000;
  localparam logic [5:0] ST_BUSY    = 6'b100000;

  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_DATA = 1'b1;

  logic              rd_state_q, rd_state_d;
  logic [RF_AW-1:0]  slot_q, slot_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [RF_AW-1:0]  resp_addr_q, resp_addr_d;
  logic              reg_en_q, reg_en_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic is_read, accept, complete;
  logic unused_addr_bits;

  // Only the word index within the register file is meaningful.
  assign unused_addr_bits = ^{ADDR[ADDR_W-1:RF_AW+2], ADDR[1:0]};

  function automatic logic [BEAT_W-1:0] beat_next(input logic first,
                                                  input logic [BEAT_W-1:0] cnt);
    if (first)     return BEAT_W'(1);
    else if (&cnt) return cnt;
    else           return cnt + 1'b1;
  endfunction

  always_comb begin
    is_read  = (state == ST_SBURSTR) || (state == ST_INCRBR);
    accept   = is_read && HREADY;
    complete = (rd_state_q == RD_DATA) && HREADY;

    rd_state_d  = rd_state_q;
    slot_d      = slot_q;
    resp_d      = resp_q;
    resp_addr_d = resp_addr_q;
    reg_en_d    = 1'b0;
    beat_d      = beat_q;
    first_d     = first_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (complete && HRESP) begin
      // An ERROR ends the sequence and drops any address phase taken alongside it.
      rd_state_d = RD_IDLE;
      err_d      = 1'b1;
      first_d    = 1'b1;
    end else begin
      if (accept) begin
        rd_state_d = RD_DATA;
        slot_d     = ADDR[RF_AW+1:2];
      end else if (complete) begin
        rd_state_d = RD_IDLE;
      end
      if (complete) begin
        resp_d      = HRDATA;
        resp_addr_d = slot_q;
        reg_en_d    = 1'b1;
        beat_d      = beat_next(first_q, beat_q);
        // BUSY pauses a burst without ending it.
        done_d      = !accept && (state != ST_BUSY);
        first_d     = done_d;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_state_q  <= RD_IDLE;
      resp_q      <= '0;
      resp_addr_q <= '0;
      reg_en_q    <= 1'b0;
      beat_q      <= '0;
      first_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      resp_q      <= resp_d;
      resp_addr_q <= resp_addr_d;
      reg_en_q    <= reg_en_d;
      beat_q      <= beat_d;
      first_q     <= first_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // The pending slot is only consulted while RD_DATA, so it needs no reset.
  always_ff @(posedge HCLK) begin
    slot_q <= slot_d;
  end

  assign RESPONSE      = resp_q;
  assign RESPONSE_ADDR = resp_addr_q;
  assign REG_ENABLE    = reg_en_q;
  assign REG_WRITE     = reg_en_q;
  assign BEAT_CNT      = beat_q;
  assign RD_DONE       = done_q;
  assign RD_ERR        = err_q;

endmodule

// File: tb/tb_ahb_burst_read_handler.sv
// Directed bench for ahb_burst_read_handler: a vector table for the main
// sequences, then hand-written reset, 64-bit and saturation sequences.
module tb_ahb_burst_read_handler;

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_SB   = 6'b000100;
  localparam logic [5:0] S_INCR = 6'b010000;
  localparam logic [5:0] S_BUSY = 6'b100000;
  localparam logic [5:0] S_NR   = 6'b000010;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [5:0]  state = S_IDLE;
  logic        HREADY = 1'b0;
  logic        HRESP = 1'b0;
  logic [63:0] HRDATA = '0;
  logic [25:0] ADDR = '0;

  logic [31:0] resp32;
  logic [4:0]  raddr32, beat32;
  logic        en32, wr32, done32, err32;
  logic [63:0] resp64;
  logic [4:0]  raddr64, beat64;
  logic        en64, wr64, done64, err64;

  int total = 0;
  int bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_burst_read_handler #(.DATA_W(32)) u32 (
    .HCLK(HCLK), .HRESETn(HRESETn), .state(state), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA[31:0]), .ADDR(ADDR), .RESPONSE(resp32), .RESPONSE_ADDR(raddr32),
    .REG_ENABLE(en32), .REG_WRITE(wr32), .BEAT_CNT(beat32), .RD_DONE(done32), .RD_ERR(err32)
  );

  ahb_burst_read_handler #(.DATA_W(64)) u64 (
    .HCLK(HCLK), .HRESETn(HRESETn), .state(state), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .ADDR(ADDR), .RESPONSE(resp64), .RESPONSE_ADDR(raddr64),
    .REG_ENABLE(en64), .REG_WRITE(wr64), .BEAT_CNT(beat64), .RD_DONE(done64), .RD_ERR(err64)
  );

  typedef struct {
    logic [5:0]  st;
    logic        rdy;
    logic        rsp;
    logic [31:0] d;
    logic [25:0] a;
    logic        en;
    logic [31:0] r;
    logic [4:0]  slot;
    logic        done;
    logic        err;
    logic [4:0]  beat;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t mk(logic [5:0] st, logic rdy, logic rsp, logic [31:0] d,
                              logic [25:0] a, logic en, logic [31:0] r, logic [4:0] slot,
                              logic done, logic err, logic [4:0] beat);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rsp = rsp; v.d = d; v.a = a;
    v.en = en; v.r = r; v.slot = slot; v.done = done; v.err = err; v.beat = beat;
    return v;
  endfunction

  function automatic logic [63:0] pack32(logic en, logic wr, logic [31:0] r, logic [4:0] slot,
                                         logic done, logic err, logic [4:0] beat);
    return {18'd0, en, wr, r, slot, done, err, beat};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [5:0] st, logic rdy, logic rsp, logic [63:0] d, logic [25:0] a);
    state = st; HREADY = rdy; HRESP = rsp; HRDATA = d; ADDR = a;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [63:0] act32();
    return pack32(en32, wr32, resp32, raddr32, done32, err32, beat32);
  endfunction

  initial begin
    // single
    tv[0]  = mk(S_SB,   1, 0, 32'h00, 26'h14, 0, 32'h00, 5'd0,  0, 0, 5'd0);
    tv[1]  = mk(S_IDLE, 1, 0, 32'h0A, 26'h00, 1, 32'h0A, 5'd5,  1, 0, 5'd1);
    tv[2]  = mk(S_IDLE, 1, 0, 32'h00, 26'h00, 0, 32'h0A, 5'd5,  0, 0, 5'd1);
    // wait states
    tv[3]  = mk(S_SB,   1, 0, 32'h00, 26'h14, 0, 32'h0A, 5'd5,  0, 0, 5'd1);
    tv[4]  = mk(S_IDLE, 0, 0, 32'h00, 26'h00, 0, 32'h0A, 5'd5,  0, 0, 5'd1);
    tv[5]  = mk(S_IDLE, 0, 0, 32'h00, 26'h00, 0, 32'h0A, 5'd5,  0, 0, 5'd1);
    tv[6]  = mk(S_IDLE, 1, 0, 32'h0A, 26'h00, 1, 32'h0A, 5'd5,  1, 0, 5'd1);
    // INCR burst of three
    tv[7]  = mk(S_INCR, 1, 0, 32'h00, 26'h14, 0, 32'h0A, 5'd5,  0, 0, 5'd1);
    tv[8]  = mk(S_INCR, 1, 0, 32'h01, 26'h18, 1, 32'h01, 5'd5,  0, 0, 5'd1);
    tv[9]  = mk(S_INCR, 1, 0, 32'h02, 26'h1C, 1, 32'h02, 5'd6,  0, 0, 5'd2);
    tv[10] = mk(S_IDLE, 1, 0, 32'h03, 26'h00, 1, 32'h03, 5'd7,  1, 0, 5'd3);
    tv[11] = mk(S_IDLE, 1, 0, 32'h00, 26'h00, 0, 32'h03, 5'd7,  0, 0, 5'd3);
    // BUSY in the middle of a burst
    tv[12] = mk(S_INCR, 1, 0, 32'h00, 26'h14, 0, 32'h03, 5'd7,  0, 0, 5'd3);
    tv[13] = mk(S_BUSY, 1, 0, 32'h11, 26'h00, 1, 32'h11, 5'd5,  0, 0, 5'd1);
    tv[14] = mk(S_INCR, 1, 0, 32'h00, 26'h18, 0, 32'h11, 5'd5,  0, 0, 5'd1);
    tv[15] = mk(S_IDLE, 1, 0, 32'h22, 26'h00, 1, 32'h22, 5'd6,  1, 0, 5'd2);
    // ERROR: first cycle waits, second completes and drops the 0x18 address phase
    tv[16] = mk(S_INCR, 1, 0, 32'h00, 26'h14, 0, 32'h22, 5'd6,  0, 0, 5'd2);
    tv[17] = mk(S_INCR, 0, 1, 32'h00, 26'h18, 0, 32'h22, 5'd6,  0, 0, 5'd2);
    tv[18] = mk(S_INCR, 1, 1, 32'h33, 26'h18, 0, 32'h22, 5'd6,  0, 1, 5'd2);
    tv[19] = mk(S_IDLE, 1, 0, 32'h44, 26'h00, 0, 32'h22, 5'd6,  0, 0, 5'd2);
    // slot wraps modulo 32: address 0x3FFFFFC -> slot 31
    tv[20] = mk(S_SB,   1, 0, 32'h00, 26'h3FFFFFC, 0, 32'h22, 5'd6, 0, 0, 5'd2);
    tv[21] = mk(S_IDLE, 1, 0, 32'h55, 26'h00, 1, 32'h55, 5'd31, 1, 0, 5'd1);
    // non-read state code does not start a transfer
    tv[22] = mk(S_NR,   1, 0, 32'h00, 26'h14, 0, 32'h55, 5'd31, 0, 0, 5'd1);
    tv[23] = mk(S_IDLE, 1, 0, 32'h66, 26'h00, 0, 32'h55, 5'd31, 0, 0, 5'd1);

    drive(S_IDLE, 1'b1, 1'b0, 64'h0, 26'h0);
    step();
    step();
    check("reset_state", act32(), pack32(0, 0, 32'h0, 5'd0, 0, 0, 5'd0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].st, tv[i].rdy, tv[i].rsp, {32'h0, tv[i].d}, tv[i].a);
      step();
      check($sformatf("vec%0d", i), act32(),
            pack32(tv[i].en, tv[i].en, tv[i].r, tv[i].slot, tv[i].done, tv[i].err, tv[i].beat));
    end

    // Asynchronous reset while HCLK is low, in the wait state of an INCR beat
    drive(S_INCR, 1, 0, 64'h0, 26'h14);
    step();
    drive(S_INCR, 0, 0, 64'h0, 26'h18);
    step();
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("async_reset", act32(), pack32(0, 0, 32'h0, 5'd0, 0, 0, 5'd0));
    #2;
    HRESETn = 1'b1;
    drive(S_IDLE, 1, 0, 64'h77, 26'h0);
    step();
    check("pending_dropped", act32(), pack32(0, 0, 32'h0, 5'd0, 0, 0, 5'd0));
    drive(S_SB, 1, 0, 64'h0, 26'h14);
    step();
    drive(S_IDLE, 1, 0, 64'h0A, 26'h0);
    step();
    check("single_after_reset", act32(), pack32(1, 1, 32'h0A, 5'd5, 1, 0, 5'd1));

    // 64-bit data path
    drive(S_INCR, 1, 0, 64'h0, 26'h14);
    step();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) drive(S_INCR, 1, 0, 64'h1_0000_0001, 26'h18 + 26'(4 * k));
      else       drive(S_IDLE, 1, 0, 64'h1_0000_0001, 26'h0);
      step();
      check($sformatf("w64_data%0d", k), resp64, 64'h1_0000_0001);
      check($sformatf("w64_ctl%0d", k), {52'd0, en64, wr64, raddr64, done64, beat64},
            {52'd0, 1'b1, 1'b1, 5'(5 + k), (k == 2), 5'(k + 1)});
    end

    // BEAT_CNT saturates at 31 on a 33-beat burst
    for (int k = 0; k < 33; k++) begin
      drive(S_INCR, 1, 0, 64'(k), 26'(4 * k));
      step();
    end
    check("beat_pre_sat", {59'd0, beat32}, 64'd31);
    drive(S_IDLE, 1, 0, 64'hAB, 26'h0);
    step();
    check("beat_saturated", act32(), pack32(1, 1, 32'hAB, 5'd0, 1, 0, 5'd31));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
